// File: rtl/deser8_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : deser8_if                                                      |
// | Brief    : Serial-in / byte-out bundle between a bit source and deser8.   |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface deser8_if;
    logic       ENB8;
    logic       START8;
    logic       S_IN8;
    logic       DIR8;
    logic       ACK8;
    logic [7:0] Q8;
    logic       VALID8;
    logic       BUSY8;
    logic       ERR8;
    logic       OVR8;

    modport master (
        output ENB8, START8, S_IN8, DIR8, ACK8,
        input  Q8, VALID8, BUSY8, ERR8, OVR8
    );

    modport slave (
        input  ENB8, START8, S_IN8, DIR8, ACK8,
        output Q8, VALID8, BUSY8, ERR8, OVR8
    );
endinterface
`default_nettype wire

// File: rtl/deser8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : deser8                                                         |
// | Brief    : 8-bit serial-to-parallel converter, selectable bit order.      |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module deser8 (
    input  wire logic CLK8,
    input  wire logic RST8,
    deser8_if.slave   bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } stateT;

    localparam logic [2:0] c_lastBit = 3'd7;

    stateT      r_state,    w_stateNext;
    logic [7:0] r_shiftReg, w_shiftRegNext;
    logic [2:0] r_bitCnt,   w_bitCntNext;
    logic       r_lDir,     w_lDirNext;
    logic [7:0] r_qByte,    w_qByteNext;
    logic       r_valid,    w_validNext;
    logic       r_err,      w_errNext;
    logic       r_ovr,      w_ovrNext;

    logic       w_dirSel;
    logic [7:0] w_srBase;
    logic [7:0] w_shifted;

    // A start bit opens a fresh frame: shift into an empty register with the new direction.
    assign w_dirSel  = bus.START8 ? bus.DIR8 : r_lDir;
    assign w_srBase  = bus.START8 ? 8'h00 : r_shiftReg;
    assign w_shifted = w_dirSel ? {bus.S_IN8, w_srBase[7:1]}
                                : {w_srBase[6:0], bus.S_IN8};

    always_ff @(posedge CLK8) begin
        if (!RST8) begin
            r_state    <= IDLE;
            r_shiftReg <= 8'h00;
            r_bitCnt   <= 3'd0;
            r_lDir     <= 1'b0;
            r_qByte    <= 8'h00;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_shiftReg <= w_shiftRegNext;
            r_bitCnt   <= w_bitCntNext;
            r_lDir     <= w_lDirNext;
            r_qByte    <= w_qByteNext;
            r_valid    <= w_validNext;
            r_err      <= w_errNext;
            r_ovr      <= w_ovrNext;
        end
    end

    always_comb begin
        w_stateNext    = r_state;
        w_shiftRegNext = r_shiftReg;
        w_bitCntNext   = r_bitCnt;
        w_lDirNext     = r_lDir;
        w_qByteNext    = r_qByte;
        w_validNext    = r_valid;
        w_errNext      = r_err;
        w_ovrNext      = r_ovr;

        if (bus.ACK8) begin
            w_validNext = 1'b0;
        end

        if (bus.ENB8) begin
            if (bus.START8) begin
                if (r_state == RECV) begin
                    w_errNext = 1'b1;
                end
                w_shiftRegNext = w_shifted;
                w_lDirNext     = bus.DIR8;
                w_bitCntNext   = 3'd1;
                w_stateNext    = RECV;
            end else if (r_state == RECV) begin
                w_shiftRegNext = w_shifted;
                w_bitCntNext   = r_bitCnt + 3'd1;
                // Completion wins over a same-edge acknowledge; overrun only if unacknowledged.
                if (r_bitCnt == c_lastBit) begin
                    w_qByteNext = w_shifted;
                    w_validNext = 1'b1;
                    if (r_valid && !bus.ACK8) begin
                        w_ovrNext = 1'b1;
                    end
                    w_stateNext = IDLE;
                end
            end
        end
    end

    assign bus.Q8     = r_qByte;
    assign bus.VALID8 = r_valid;
    assign bus.BUSY8  = (r_state == RECV);
    assign bus.ERR8   = r_err;
    assign bus.OVR8   = r_ovr;
endmodule
`default_nettype wire

// File: tb/tb_deser8.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_deser8                                                      |
// | Brief    : Directed scoreboard bench for deser8.                          |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_deser8;
    typedef struct {
        logic [7:0] q;
        logic       err;
        logic       ovr;
    } expT;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    bit   stimDone = 0;
    expT  expQueue[$];

    deser8_if bus();

    deser8 dut (
        .CLK8 (clk),
        .RST8 (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic en, input logic st, input logic s,
                         input logic dir, input logic ack);
        bus.ENB8   = en;
        bus.START8 = st;
        bus.S_IN8  = s;
        bus.DIR8   = dir;
        bus.ACK8   = ack;
        @(posedge clk);
        #1;
        bus.ENB8   = 1'b0;
        bus.START8 = 1'b0;
        bus.ACK8   = 1'b0;
    endtask

    // seq[7] is the first bit on the wire; ackLast raises ACK8 with the final bit.
    task automatic sendSeq(input logic [7:0] seq, input logic dir, input logic ackLast);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, (i == 7), seq[i], dir, ackLast && (i == 0));
        end
    endtask

    task automatic pushExp(input logic [7:0] q, input logic err, input logic ovr);
        expT e;
        e.q   = q;
        e.err = err;
        e.ovr = ovr;
        expQueue.push_back(e);
    endtask

    // Monitor: a new byte is presented when VALID8 rises or Q8 changes while valid.
    initial begin : monitor
        logic       prevValid;
        logic [7:0] prevQ;
        expT        e;
        prevValid = 1'b0;
        prevQ     = 8'h00;
        forever begin
            @(negedge clk);
            if (rst && bus.VALID8 && (!prevValid || bus.Q8 != prevQ)) begin
                if (expQueue.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%02h expected none", bus.Q8);
                end else begin
                    e = expQueue.pop_front();
                    check("sb_q", bus.Q8, e.q);
                    check("sb_err", {7'd0, bus.ERR8}, {7'd0, e.err});
                    check("sb_ovr", {7'd0, bus.OVR8}, {7'd0, e.ovr});
                end
            end
            prevValid = bus.VALID8;
            prevQ     = bus.Q8;
        end
    end

    initial begin : stimulus
        bus.ENB8 = 0; bus.START8 = 0; bus.S_IN8 = 0; bus.DIR8 = 0; bus.ACK8 = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", bus.Q8, 8'h00);
        check("rst_valid", {7'd0, bus.VALID8}, 8'd0);
        check("rst_busy", {7'd0, bus.BUSY8}, 8'd0);
        check("rst_err", {7'd0, bus.ERR8}, 8'd0);
        check("rst_ovr", {7'd0, bus.OVR8}, 8'd0);
        rst = 1'b1;

        // Idle noise: bits without start, and start without enable, are ignored.
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("idle_busy", {7'd0, bus.BUSY8}, 8'd0);

        // MSB-first
        pushExp(8'hCA, 1'b0, 1'b0);
        sendSeq(8'hCA, 1'b0, 1'b0);
        check("msb_busy", {7'd0, bus.BUSY8}, 8'd0);
        check("msb_valid", {7'd0, bus.VALID8}, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ack_valid", {7'd0, bus.VALID8}, 8'd0);

        // LSB-first, same wire sequence
        pushExp(8'h53, 1'b0, 1'b0);
        sendSeq(8'hCA, 1'b1, 1'b0);
        check("lsb_q", bus.Q8, 8'h53);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Gapped: DIR8 flips after the start bit; disabled cycles carry junk
        pushExp(8'hCA, 1'b0, 1'b0);
        begin
            logic [7:0] seq;
            seq = 8'hCA;
            for (int i = 7; i >= 0; i--) begin
                drive(1'b1, (i == 7), seq[i], (i != 7), 1'b0);
                if (i == 4) begin
                    check("gap_busy", {7'd0, bus.BUSY8}, 8'd1);
                    check("gap_q_hidden", bus.Q8, 8'h53);
                end
                if (i != 0) drive(1'b0, 1'b1, ~seq[i], 1'b1, 1'b0);
            end
        end
        check("gap_valid", {7'd0, bus.VALID8}, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Overrun
        pushExp(8'hCA, 1'b0, 1'b0);
        sendSeq(8'hCA, 1'b0, 1'b0);
        pushExp(8'h35, 1'b0, 1'b1);
        sendSeq(8'h35, 1'b0, 1'b0);
        check("ovr_q", bus.Q8, 8'h35);
        check("ovr_flag", {7'd0, bus.OVR8}, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_ack_valid", {7'd0, bus.VALID8}, 8'd0);
        check("ovr_sticky", {7'd0, bus.OVR8}, 8'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("ack_idle_q", bus.Q8, 8'h35);

        // Reset mid-frame
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        check("mid_rst_q", bus.Q8, 8'h00);
        check("mid_rst_busy", {7'd0, bus.BUSY8}, 8'd0);
        check("mid_rst_ovr", {7'd0, bus.OVR8}, 8'd0);
        check("mid_rst_valid", {7'd0, bus.VALID8}, 8'd0);

        // Framing: restart on the 4th bit, then 0xA5 with the restart bit as its bit 0
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        pushExp(8'hA5, 1'b1, 1'b0);
        sendSeq(8'hA5, 1'b0, 1'b0);
        check("frm_err", {7'd0, bus.ERR8}, 8'd1);

        // Completion with same-edge ACK: new byte, VALID stays, no overrun
        pushExp(8'h3C, 1'b1, 1'b0);
        sendSeq(8'h3C, 1'b0, 1'b1);
        check("ackdone_valid", {7'd0, bus.VALID8}, 8'd1);
        check("ackdone_ovr", {7'd0, bus.OVR8}, 8'd0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 8'(expQueue.size()), 8'd0);
        stimDone = 1;
    end

    initial begin : finisher
        fork
            wait (stimDone);
            begin
                #20000;
                checks++;
                errors++;
                $display("FAIL timeout: got running expected done");
            end
        join_any
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/deser8.md
DESER8 -- requirements
Module: deser8

Interface
REQ-001 The block SHALL have the port CLK8, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port RST8, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have the port ENB8, input, 1 bit: bit-valid qualifier; S_IN8 and START8 are sampled only when ENB8=1.
REQ-004 The block SHALL have the port START8, input, 1 bit: marks the cycle carrying bit 0 of a frame.
REQ-005 The block SHALL have the port S_IN8, input, 1 bit: serial data in.
REQ-006 The block SHALL have the port DIR8, input, 1 bit: 0 = MSB-first, 1 = LSB-first; sampled only on the start bit.
REQ-007 The block SHALL have the port ACK8, input, 1 bit: consumer acknowledge; clears VALID8.
REQ-008 The block SHALL have the port Q8, output, 8 bits: last completed byte.
REQ-009 The block SHALL have the port VALID8, output, 1 bit: level; Q8 holds unconsumed data.
REQ-010 The block SHALL have the port BUSY8, output, 1 bit: 1 while a frame is in progress (state RECV).
REQ-011 The block SHALL have the port ERR8, output, 1 bit: sticky framing error.
REQ-012 The block SHALL have the port OVR8, output, 1 bit: sticky overrun.

Function
REQ-013 The FSM SHALL have two states: IDLE and RECV; internal state SHALL be an 8-bit shift register SR, a 3-bit bit counter CNT and a latched direction bit LDIR.
REQ-014 In IDLE, ENB8=1 with START8=1 SHALL capture S_IN8 as bit 0, latch LDIR=DIR8, set CNT=1 and enter RECV; START8 with ENB8=0 SHALL be ignored.
REQ-015 In IDLE, ENB8=1 with START8=0 SHALL discard S_IN8 and leave all state unchanged.
REQ-016 In RECV, each ENB8=1 cycle SHALL capture one bit and increment CNT; ENB8=0 cycles SHALL hold SR, CNT and the state.
REQ-017 For LDIR=0, each capture SHALL shift SR as {SR[6:0], S_IN8}, so the first bit ends in Q8[7].
REQ-018 For LDIR=1, each capture SHALL shift SR as {S_IN8, SR[7:1]}, so the first bit ends in Q8[0].
REQ-019 On the edge capturing the 8th bit (CNT=7), the block SHALL load the assembled byte into Q8, set VALID8=1 and return to IDLE, so Q8 and VALID8 are visible the cycle after the 8th bit.
REQ-020 START8=1 with ENB8=1 while in RECV SHALL set ERR8=1, discard the partial frame, and restart reception with the current bit as bit 0, latching LDIR=DIR8 and setting CNT=1.
REQ-021 ACK8=1 SHALL clear VALID8 on the next edge unless a byte completes on that same edge.
REQ-022 If a byte completes while VALID8=1 and ACK8=0, the block SHALL overwrite Q8 with the new byte, keep VALID8=1 and set OVR8=1.
REQ-023 If a byte completes while VALID8=1 and ACK8=1, Q8 SHALL take the new byte, VALID8 SHALL stay 1 and OVR8 SHALL be unchanged.
REQ-024 ACK8 while VALID8=0 SHALL have no effect.
REQ-025 Q8 SHALL change only on frame completion or reset; the partial content of SR SHALL never be visible on Q8.
REQ-026 ERR8 and OVR8 SHALL remain set until reset.

Reset
REQ-027 RST8=0 at a rising CLK8 edge SHALL force IDLE, with SR=0x00, CNT=0, LDIR=0, Q8=0x00, VALID8=0, BUSY8=0, ERR8=0 and OVR8=0, regardless of all other inputs.
REQ-028 Reset during RECV SHALL discard the partial frame with no VALID8 pulse and no error flag; the first post-reset START8 SHALL begin a clean frame.

Verification
REQ-029 Reset test: hold RST8=0 for 1 cycle mid-frame -> all outputs 0 and BUSY8=0 the next cycle.
REQ-030 MSB-first test: DIR8=0, ENB8=1 continuously, START8 on the first bit, bits 1,1,0,0,1,0,1,0 -> Q8=0xCA and VALID8=1 the cycle after the 8th bit, BUSY8=0.
REQ-031 LSB-first test: DIR8=1 with the same bit sequence -> Q8=0x53 and VALID8=1.
REQ-032 Gapped test: ENB8 toggling 1/0 while DIR8 flips after the start bit -> Q8=0xCA, since DIR8 is honoured only at the start bit and VALID8 rises after 8 enabled cycles.
REQ-033 Overrun test: send 0xCA then 0x35 MSB-first without ACK8 -> Q8=0x35, VALID8=1, OVR8=1; then ACK8 pulse -> VALID8=0 with OVR8 still 1.
REQ-034 Framing test: START8 re-asserted on the 4th bit of a frame, then 8 bits of 0xA5 MSB-first -> ERR8=1, Q8=0xA5, VALID8=1, OVR8=0.
